// File: rtl/fusion_pkg.sv
// Shared constants, FSM state encoding and element helpers for the track-fusion scheduler.
package fusion_pkg;

    localparam int N_ELEM     = 6;
    localparam int W_DATA     = 16;
    localparam int W_PF       = 32;
    localparam int W_NUM      = 34;
    localparam int W_DEN      = 17;
    localparam int DIV_CYCLES = 33;
    localparam int W_TRK      = N_ELEM * W_DATA;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_DIV_X = 3'd2,
        ST_DIV_P = 3'd3,
        ST_EMIT  = 3'd4
    } state_t;

    function automatic logic [W_DATA-1:0] elem_slice(input logic [W_TRK-1:0] trk,
                                                     input logic [2:0]       idx);
        elem_slice = trk[int'(idx)*W_DATA +: W_DATA];
    endfunction

    function automatic logic [W_DATA-1:0] sat_data(input logic signed [W_NUM-1:0] q);
        if (q > 34'sd32767) begin
            sat_data = 16'h7FFF;
        end else if (q < -34'sd32768) begin
            sat_data = 16'h8000;
        end else begin
            sat_data = q[W_DATA-1:0];
        end
    endfunction

endpackage

// File: rtl/fusion_div.sv
// Restoring divider: signed 34-bit dividend by unsigned 17-bit divisor, truncating toward zero.
// done pulses exactly DIV_CYCLES cycles after the start cycle; the first iteration runs on the start edge.
module fusion_div
    import fusion_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic signed [W_NUM-1:0] dividend,
    input  logic [W_DEN-1:0]        divisor,
    output logic signed [W_NUM-1:0] quotient,
    output logic                    done
);

    localparam int W_MAG = W_NUM - 1;
    localparam int W_REM = W_DEN + 1;

    logic [W_MAG-1:0] shf_r;
    logic [W_REM-1:0] rem_r;
    logic [W_DEN-1:0] dvs_r;
    logic             neg_r;
    logic [5:0]       cnt_r;
    logic             busy_r;
    logic             done_r;

    logic [W_MAG-1:0] mag_s;
    logic [W_MAG-1:0] shf_in_s;
    logic [W_REM-1:0] rem_in_s;
    logic [W_DEN-1:0] dvs_in_s;
    logic [W_REM-1:0] trial_s;
    logic [W_MAG-1:0] shf_nx_s;
    logic [W_REM-1:0] rem_nx_s;

    // One shift-subtract step, seeded from the fresh operands on start
    always_comb begin
        if (dividend[W_NUM-1]) begin
            mag_s = W_MAG'(-dividend);
        end else begin
            mag_s = dividend[W_MAG-1:0];
        end
        if (start) begin
            shf_in_s = mag_s;
            rem_in_s = {W_REM{1'b0}};
            dvs_in_s = divisor;
        end else begin
            shf_in_s = shf_r;
            rem_in_s = rem_r;
            dvs_in_s = dvs_r;
        end
        trial_s = {rem_in_s[W_REM-2:0], shf_in_s[W_MAG-1]};
        if (trial_s >= {1'b0, dvs_in_s}) begin
            rem_nx_s = trial_s - {1'b0, dvs_in_s};
            shf_nx_s = {shf_in_s[W_MAG-2:0], 1'b1};
        end else begin
            rem_nx_s = trial_s;
            shf_nx_s = {shf_in_s[W_MAG-2:0], 1'b0};
        end
    end

    // Iteration state and done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            shf_r  <= {W_MAG{1'b0}};
            rem_r  <= {W_REM{1'b0}};
            dvs_r  <= {W_DEN{1'b0}};
            neg_r  <= 1'b0;
            cnt_r  <= 6'd0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else if (start) begin
            shf_r  <= shf_nx_s;
            rem_r  <= rem_nx_s;
            dvs_r  <= divisor;
            neg_r  <= dividend[W_NUM-1];
            cnt_r  <= 6'(DIV_CYCLES - 1);
            busy_r <= 1'b1;
            done_r <= 1'b0;
        end else if (busy_r) begin
            shf_r  <= shf_nx_s;
            rem_r  <= rem_nx_s;
            cnt_r  <= cnt_r - 6'd1;
            busy_r <= (cnt_r != 6'd1);
            done_r <= (cnt_r == 6'd1);
        end else begin
            done_r <= 1'b0;
        end
    end

    // Sign restored after magnitude division
    always_comb begin
        if (neg_r) begin
            quotient = -$signed({1'b0, shf_r});
        end else begin
            quotient = $signed({1'b0, shf_r});
        end
    end

    assign done = done_r;

endmodule

// File: rtl/fusion_scheduler.sv
// Round-robin scheduler feeding one element-serial covariance-weighted fusion datapath.
module fusion_scheduler
    import fusion_pkg::*;
#(
    parameter int N_CH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_CH-1:0]       req_valid,
    output logic [N_CH-1:0]       req_ready,
    input  logic [N_CH*W_TRK-1:0] req_p1,
    input  logic [N_CH*W_TRK-1:0] req_p2,
    input  logic [N_CH*W_TRK-1:0] req_x1,
    input  logic [N_CH*W_TRK-1:0] req_x2,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2:0]            out_chan,
    output logic [2:0]            out_idx,
    output logic [W_DATA-1:0]     out_xf,
    output logic [W_PF-1:0]       out_pf,
    output logic                  out_err,
    output logic                  out_last
);

    state_t                  state_r;
    logic [2:0]              rr_ptr_r;
    logic [2:0]              idx_r;
    logic [W_TRK-1:0]        p1_r, p2_r, x1_r, x2_r;
    logic signed [W_NUM-1:0] prod_r;
    logic [W_DEN-1:0]        den_r;
    logic [W_DATA-1:0]       xf_r;

    logic                    out_valid_r;
    logic [2:0]              out_chan_r;
    logic [2:0]              out_idx_r;
    logic [W_DATA-1:0]       out_xf_r;
    logic [W_PF-1:0]         out_pf_r;
    logic                    out_err_r;
    logic                    out_last_r;

    logic                    grant_valid_s;
    logic [2:0]              grant_ch_s;
    logic signed [W_DATA-1:0] p1e_s, p2e_s, x1e_s, x2e_s;
    logic signed [W_NUM-1:0] p1w_s, p2w_s, x1w_s, x2w_s;
    logic signed [W_NUM-1:0] num_s, prod_s;
    logic [W_DEN-1:0]        den_s;
    logic                    bad_s;

    logic                    div_start_s;
    logic signed [W_NUM-1:0] div_dvd_s;
    logic [W_DEN-1:0]        div_dvs_s;
    logic signed [W_NUM-1:0] div_quot_s;
    logic                    div_done_s;

    // Rotate-priority search starting just after the last granted channel
    always_comb begin
        grant_valid_s = 1'b0;
        grant_ch_s    = rr_ptr_r;
        for (int k = 1; k <= N_CH; k++) begin
            int   cand;
            logic hit;
            cand          = int'(rr_ptr_r) + k;
            cand          = (cand >= N_CH) ? cand - N_CH : cand;
            hit           = !grant_valid_s && req_valid[cand];
            grant_ch_s    = hit ? 3'(cand) : grant_ch_s;
            grant_valid_s = grant_valid_s | hit;
        end
        for (int c = 0; c < N_CH; c++) begin
            req_ready[c] = (state_r == ST_IDLE) && grant_valid_s && (grant_ch_s == 3'(c));
        end
    end

    // Operands of the current element
    always_comb begin
        p1e_s  = elem_slice(p1_r, idx_r);
        p2e_s  = elem_slice(p2_r, idx_r);
        x1e_s  = elem_slice(x1_r, idx_r);
        x2e_s  = elem_slice(x2_r, idx_r);
        p1w_s  = W_NUM'(p1e_s);
        p2w_s  = W_NUM'(p2e_s);
        x1w_s  = W_NUM'(x1e_s);
        x2w_s  = W_NUM'(x2e_s);
        num_s  = p2w_s * x1w_s + p1w_s * x2w_s;
        prod_s = p1w_s * p2w_s;
        den_s  = p1w_s[W_DEN-1:0] + p2w_s[W_DEN-1:0];
        bad_s  = (p1e_s <= 16'sd0) || (p2e_s <= 16'sd0);
    end

    // The shared divider takes num/den from LOAD, then prod/den when the state quotient lands
    always_comb begin
        case (state_r)
            ST_LOAD: begin
                div_start_s = !bad_s;
                div_dvd_s   = num_s;
                div_dvs_s   = den_s;
            end
            ST_DIV_X: begin
                div_start_s = div_done_s;
                div_dvd_s   = prod_r;
                div_dvs_s   = den_r;
            end
            default: begin
                div_start_s = 1'b0;
                div_dvd_s   = {W_NUM{1'b0}};
                div_dvs_s   = {W_DEN{1'b0}};
            end
        endcase
    end

    fusion_div u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start_s),
        .dividend (div_dvd_s),
        .divisor  (div_dvs_s),
        .quotient (div_quot_s),
        .done     (div_done_s)
    );

    // Scheduler FSM with registered output stage
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            rr_ptr_r    <= 3'(N_CH - 1);
            idx_r       <= 3'd0;
            p1_r        <= {W_TRK{1'b0}};
            p2_r        <= {W_TRK{1'b0}};
            x1_r        <= {W_TRK{1'b0}};
            x2_r        <= {W_TRK{1'b0}};
            prod_r      <= {W_NUM{1'b0}};
            den_r       <= {W_DEN{1'b0}};
            xf_r        <= {W_DATA{1'b0}};
            out_valid_r <= 1'b0;
            out_chan_r  <= 3'd0;
            out_idx_r   <= 3'd0;
            out_xf_r    <= {W_DATA{1'b0}};
            out_pf_r    <= {W_PF{1'b0}};
            out_err_r   <= 1'b0;
            out_last_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (grant_valid_s) begin
                        p1_r     <= req_p1[int'(grant_ch_s)*W_TRK +: W_TRK];
                        p2_r     <= req_p2[int'(grant_ch_s)*W_TRK +: W_TRK];
                        x1_r     <= req_x1[int'(grant_ch_s)*W_TRK +: W_TRK];
                        x2_r     <= req_x2[int'(grant_ch_s)*W_TRK +: W_TRK];
                        rr_ptr_r <= grant_ch_s;
                        idx_r    <= 3'd0;
                        state_r  <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    den_r  <= den_s;
                    prod_r <= prod_s;
                    if (bad_s) begin
                        out_valid_r <= 1'b1;
                        out_chan_r  <= rr_ptr_r;
                        out_idx_r   <= idx_r;
                        out_xf_r    <= x1e_s;
                        out_pf_r    <= {W_PF{1'b0}};
                        out_err_r   <= 1'b1;
                        out_last_r  <= (idx_r == 3'(N_ELEM - 1));
                        state_r     <= ST_EMIT;
                    end else begin
                        state_r <= ST_DIV_X;
                    end
                end
                ST_DIV_X: begin
                    if (div_done_s) begin
                        xf_r    <= sat_data(div_quot_s);
                        state_r <= ST_DIV_P;
                    end
                end
                ST_DIV_P: begin
                    if (div_done_s) begin
                        out_valid_r <= 1'b1;
                        out_chan_r  <= rr_ptr_r;
                        out_idx_r   <= idx_r;
                        out_xf_r    <= xf_r;
                        out_pf_r    <= div_quot_s[W_PF-1:0];
                        out_err_r   <= 1'b0;
                        out_last_r  <= (idx_r == 3'(N_ELEM - 1));
                        state_r     <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        if (idx_r == 3'(N_ELEM - 1)) begin
                            state_r <= ST_IDLE;
                        end else begin
                            idx_r   <= idx_r + 3'd1;
                            state_r <= ST_LOAD;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign out_valid = out_valid_r;
    assign out_chan  = out_chan_r;
    assign out_idx   = out_idx_r;
    assign out_xf    = out_xf_r;
    assign out_pf    = out_pf_r;
    assign out_err   = out_err_r;
    assign out_last  = out_last_r;

endmodule

// File: doc/fusion_scheduler.md
# fusion_scheduler

Round-robin scheduler that shares one sequential scalar fusion datapath between `N_CH` sensor-pair requesters. It latches a complete 6-element track pair (diagonal covariances P1/P2, states X1/X2) from the granted channel. It then sequences the elements one at a time through a shared divider and streams fused results (Xf, Pf) element-serially over a valid/ready output. It sits between the per-sensor track buffers and the fused-track store.

## Interface
- `N_CH`, 2: number of requester channels (2..8).
- `N_ELEM`, 6: elements per track (fixed by the package; not overridable).
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  N_CH  channel c has a track pair pending.
- `req_ready`  out  N_CH  one-hot grant/accept pulse; the transfer occurs when `req_valid[c] & req_ready[c]`.
- `req_p1`, `req_p2`  in  N_CH*96  signed 16-bit diagonal covariances. Element e of channel c is at bits [c*96+e*16 +: 16].
- `req_x1`, `req_x2`  in  N_CH*96  signed 16-bit states, packed the same way.
- `out_valid`  out  1  fused element available.
- `out_ready`  in  1  downstream accepts.
- `out_chan`  out  3  source channel.
- `out_idx`  out  3  element index, 0..5.
- `out_xf`  out  16  signed fused state.
- `out_pf`  out  32  fused covariance, zero-extended.
- `out_err`  out  1  element had a non-positive covariance.
- `out_last`  out  1  `out_idx == 5`.

## Operation
- FSM states: IDLE, LOAD, DIV_X, DIV_P, EMIT.
- IDLE
  - If any `req_valid` is set, grant the first valid channel after `rr_ptr` (wrapping).
  - Drive `req_ready[g]` combinationally in that cycle only.
  - Capture all 24 words, set `rr_ptr <= g` and `idx <= 0`, then go to LOAD.
  - `req_ready` is 0 in every other state.
- LOAD computes, for element `idx`:
  - `den = P1+P2` (17-bit).
  - `num = P2*X1 + P1*X2` (34-bit signed).
  - `prod = P1*P2` (34-bit).
  - If `P1 <= 0` or `P2 <= 0`: set `xf = X1`, `pf = 0`, `err = 1`, and go directly to EMIT.
  - Otherwise start the divider on `num/den` and go to DIV_X.
- DIV_X: wait for divider `done`; store the quotient, saturated to [-32768, 32767], in `xf`. Start `prod/den` and go to DIV_P.
- DIV_P: on `done`, store the quotient in `pf` with `err = 0`, then go to EMIT.
- EMIT: `out_valid = 1` and all `out_*` are registered and held stable until `out_ready`. On the handshake:
  - if `idx == 5`, go to IDLE;
  - otherwise `idx++` and go to LOAD.
- Division truncates toward zero: magnitude division, with the sign applied afterwards.
- Round-robin fairness: a channel that is continuously requesting waits at most `N_CH-1` tracks.
- `req_valid` deasserting while not granted is legal. The captured data is independent of later changes to the `req_*` inputs.

## Timing
- Reset values:
  - `req_ready = 0`, `out_valid = 0`, and all `out_*` buses 0.
  - FSM in IDLE, `idx = 0`.
  - `rr_ptr = N_CH-1`, so channel 0 wins first.
  - Divider idle.
- Divider: `done` is a 1-cycle pulse exactly 33 cycles after the `start` cycle.
- With the accept at cycle 0 and `out_ready` held high:
  - LOAD is at cycle 1.
  - DIV_X covers cycles 2–34; DIV_P covers cycles 35–67.
  - Element 0 `out_valid` is at cycle 68.
  - Per-element period is 68 cycles, so element k appears at cycle 68·(k+1). Element 5 appears at cycle 408.
  - IDLE is at cycle 409, which is the earliest next grant.
- An error element takes 2 cycles (LOAD, EMIT).
- A stall on `out_ready` adds its cycles 1:1. Outputs do not change while `out_valid & !out_ready`.
- `rst` asserted in any state, including mid-division or EMIT, returns everything to reset values on the next edge. The partial track is discarded and never re-requested.
- Simultaneous requests in IDLE are resolved in the same cycle by the rotate-priority rule.

## Structure
- `fusion_pkg` holds:
  - `N_ELEM = 6`, `W_DATA = 16`, `W_PF = 32`, `W_NUM = 34`, `DIV_CYCLES = 33`;
  - the FSM state enum;
  - the element-slice helper function.
- Sub-module `fusion_div`: 33-iteration restoring divider.
  - Inputs: 34-bit signed dividend, 17-bit unsigned divisor, `start`.
  - Outputs: 34-bit signed quotient, `done`.
  - Shared by DIV_X and DIV_P.

## Test plan
- **Basic track.** Channel 0 sends P1 = {20,30,40,50,60,70}, P2 = {10,15,20,25,30,35}, X1 = {100,110,…,150}, X2 = {80,90,…,130}.
  - Element 0: `xf` = 2600/30 = 86, `pf` = 200/30 = 6, at cycle 68.
  - Element 1: `xf` = 4350/45 = 96, `pf` = 10.
  - `out_last` only on `idx` 5, at cycle 408.
- **Negative states.** X1 = -100, X2 = -80 on element 0 with the same P → `xf` = -86, `pf` = 6.
- **Error path.** P1[2] = 0 → element 2 has `err = 1`, `xf = X1[2]`, `pf = 0`, and is emitted 2 cycles after the element-1 handshake.
- **Arbitration.** Both channels valid out of reset → channel 0 is granted first and channel 1 at cycle 409; `req_ready` is never asserted for both at once.
- **Backpressure.** `out_ready = 0` for 10 cycles at element 3 → outputs stay stable and element 4 is delayed by exactly 10 cycles.
- **Reset mid-division.** `rst` during DIV_X of element 1 → next cycle all outputs are 0 and the FSM is in IDLE. A new request is granted to channel 0, and element 0 appears 68 cycles after the accept.
